// File: rtl/dtcm_ctrl_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : dtcm_ctrl_pipe
//  Description : Pipelined DTCM controller between the LSU command/response
//                channels and a synchronous single-port data SRAM with a
//                one-cycle read latency. Both channels use a valid/ready
//                handshake. Responses return in order, misaligned accesses
//                return an error, and a small response buffer absorbs
//                backpressure.
//
//  Build option: DTCM_CTRL_RSP_BUF_EN
//                  defined   -> 2-entry response FIFO, one command per cycle
//                  undefined -> 1-entry hold register, one command per two
//                               cycles
//
//  Ports
//    clk, rst_n               clock, asynchronous active-low reset
//    lsu2dtcm_cmd_*           command channel (valid/ready, read, addr,
//                             wmask, wdata)
//    lsu2dtcm_rsp_*           response channel (valid/ready, rdata, err)
//    dtcm_ram_cs/we/addr/wem/din
//                             SRAM request, combinational from the command
//    dtcm_ram_dout            SRAM read data, valid the cycle after cs
//
//  Revision    : 1.0 - initial release
// ============================================================================
module dtcm_ctrl_pipe #(
    parameter int DTCM_AW     = 16,
    parameter int DTCM_DW     = 32,
    parameter int DTCM_MW     = DTCM_DW / 8,
    parameter int DTCM_RAM_AW = DTCM_AW - $clog2(DTCM_MW)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   lsu2dtcm_cmd_valid,
    output logic                   lsu2dtcm_cmd_ready,
    input  logic                   lsu2dtcm_cmd_read,
    input  logic [DTCM_AW-1:0]     lsu2dtcm_cmd_addr,
    input  logic [DTCM_MW-1:0]     lsu2dtcm_cmd_wmask,
    input  logic [DTCM_DW-1:0]     lsu2dtcm_cmd_wdata,
    output logic                   lsu2dtcm_rsp_valid,
    input  logic                   lsu2dtcm_rsp_ready,
    output logic [DTCM_DW-1:0]     lsu2dtcm_rsp_rdata,
    output logic                   lsu2dtcm_rsp_err,
    output logic                   dtcm_ram_cs,
    output logic                   dtcm_ram_we,
    output logic [DTCM_RAM_AW-1:0] dtcm_ram_addr,
    output logic [DTCM_MW-1:0]     dtcm_ram_wem,
    output logic [DTCM_DW-1:0]     dtcm_ram_din,
    input  logic [DTCM_DW-1:0]     dtcm_ram_dout
);

    localparam int c_OFF_W = $clog2(DTCM_MW);
`ifdef DTCM_CTRL_RSP_BUF_EN
    localparam int c_DEPTH = 2;
`else
    localparam int c_DEPTH = 1;
`endif
    localparam int c_CNT_W = $clog2(c_DEPTH + 1);

    logic                 w_misalign;
    logic                 w_accept;
    logic                 w_ram_go;
    logic                 r_pend;
    logic                 r_pend_read;
    logic                 r_pend_err;
    logic [DTCM_DW-1:0]   w_s1_data;
    logic [DTCM_DW:0]     w_s1;       // {err, rdata} of the stage-1 response
    logic [DTCM_DW:0]     w_head;     // {err, rdata} at the buffer head
    logic [DTCM_DW:0]     w_rsp;
    logic [c_CNT_W-1:0]   r_count;
    logic [c_CNT_W:0]     w_occ;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;

    // Byte-offset check; a one-byte data path has no offset bits at all.
    generate
        if (c_OFF_W > 0) begin : g_off
            assign w_misalign = |lsu2dtcm_cmd_addr[c_OFF_W-1:0];
        end else begin : g_no_off
            assign w_misalign = 1'b0;
        end
    endgenerate

    // Readiness uses registered state only, so rsp_ready never reaches
    // cmd_ready combinationally. Every slot, in flight or buffered, counts.
    assign w_occ              = {{c_CNT_W{1'b0}}, r_pend} + {1'b0, r_count};
    assign lsu2dtcm_cmd_ready = (w_occ < (c_CNT_W + 1)'(c_DEPTH));
    assign w_accept           = lsu2dtcm_cmd_valid & lsu2dtcm_cmd_ready;

    // SRAM request; a misaligned command never touches the array.
    assign w_ram_go      = w_accept & ~w_misalign;
    assign dtcm_ram_cs   = w_ram_go;
    assign dtcm_ram_we   = w_ram_go & ~lsu2dtcm_cmd_read;
    assign dtcm_ram_addr = lsu2dtcm_cmd_addr[DTCM_AW-1:c_OFF_W];
    assign dtcm_ram_wem  = (w_ram_go & ~lsu2dtcm_cmd_read) ? lsu2dtcm_cmd_wmask
                                                            : {DTCM_MW{1'b0}};
    assign dtcm_ram_din  = lsu2dtcm_cmd_wdata;

    // Stage 1: marks the cycle in which dtcm_ram_dout carries our data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend      <= 1'b0;
            r_pend_read <= 1'b0;
            r_pend_err  <= 1'b0;
        end else begin
            r_pend      <= w_accept;
            r_pend_read <= w_accept & lsu2dtcm_cmd_read;
            r_pend_err  <= w_accept & w_misalign;
        end
    end

    assign w_s1_data = (r_pend_read & ~r_pend_err) ? dtcm_ram_dout : {DTCM_DW{1'b0}};
    assign w_s1      = {r_pend_err, w_s1_data};

    // An empty buffer lets stage 1 bypass straight to the response port.
    // Anything stage 1 cannot hand over this cycle is queued behind the head.
    assign w_empty = (r_count == '0);
    assign w_pop   = ~w_empty & lsu2dtcm_rsp_ready;
    assign w_push  = r_pend & ~(w_empty & lsu2dtcm_rsp_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_push && !w_pop) begin
            r_count <= r_count + c_CNT_W'(1);
        end else if (w_pop && !w_push) begin
            r_count <= r_count - c_CNT_W'(1);
        end
    end

    generate
        if (c_DEPTH > 1) begin : g_buf_fifo
            logic [DTCM_DW:0] r_ent [2];
            logic             r_wptr;
            logic             r_rptr;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_wptr <= 1'b0;
                    r_rptr <= 1'b0;
                end else begin
                    if (w_push) r_wptr <= ~r_wptr;
                    if (w_pop)  r_rptr <= ~r_rptr;
                end
            end

            // Payload needs no reset: it is only visible while r_count != 0.
            always_ff @(posedge clk) begin
                if (w_push) r_ent[r_wptr] <= w_s1;
            end

            assign w_head = r_ent[r_rptr];
        end else begin : g_buf_hold
            logic [DTCM_DW:0] r_hold;

            always_ff @(posedge clk) begin
                if (w_push) r_hold <= w_s1;
            end

            assign w_head = r_hold;
        end
    endgenerate

    assign w_rsp              = w_empty ? w_s1 : w_head;
    assign lsu2dtcm_rsp_valid = ~w_empty | r_pend;
    assign lsu2dtcm_rsp_rdata = w_rsp[DTCM_DW-1:0];
    assign lsu2dtcm_rsp_err   = w_rsp[DTCM_DW];

endmodule
`default_nettype wire

// File: tb/tb_dtcm_ctrl_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dtcm_ctrl_pipe
//  Description : Self-checking bench for dtcm_ctrl_pipe. A behavioural SRAM
//                sits on the RAM port; a reference memory plus an in-order
//                queue of expected responses predicts every handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dtcm_ctrl_pipe;

    localparam int c_AW  = 16;
    localparam int c_DW  = 32;
    localparam int c_MW  = 4;
    localparam int c_RAW = 14;
`ifdef DTCM_CTRL_RSP_BUF_EN
    localparam int c_D = 2;
`else
    localparam int c_D = 1;
`endif

    typedef struct packed {
        logic            err;
        logic [c_DW-1:0] data;
    } rsp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_read = 1'b0;
    logic [c_AW-1:0]   cmd_addr = '0;
    logic [c_MW-1:0]   cmd_wmask = '0;
    logic [c_DW-1:0]   cmd_wdata = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [c_DW-1:0]   rsp_rdata;
    logic              rsp_err;
    logic              ram_cs;
    logic              ram_we;
    logic [c_RAW-1:0]  ram_addr;
    logic [c_MW-1:0]   ram_wem;
    logic [c_DW-1:0]   ram_din;
    logic [c_DW-1:0]   ram_dout = '0;

    // backdoor preload port into the SRAM model
    logic              bd_we = 1'b0;
    logic [5:0]        bd_addr = '0;
    logic [c_DW-1:0]   bd_data = '0;

    logic [c_DW-1:0]   ram [64];
    logic [c_DW-1:0]   ref_mem [64];
    rsp_t              sb [$];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dtcm_ctrl_pipe #(
        .DTCM_AW (c_AW),
        .DTCM_DW (c_DW)
    ) u_dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .lsu2dtcm_cmd_valid (cmd_valid),
        .lsu2dtcm_cmd_ready (cmd_ready),
        .lsu2dtcm_cmd_read  (cmd_read),
        .lsu2dtcm_cmd_addr  (cmd_addr),
        .lsu2dtcm_cmd_wmask (cmd_wmask),
        .lsu2dtcm_cmd_wdata (cmd_wdata),
        .lsu2dtcm_rsp_valid (rsp_valid),
        .lsu2dtcm_rsp_ready (rsp_ready),
        .lsu2dtcm_rsp_rdata (rsp_rdata),
        .lsu2dtcm_rsp_err   (rsp_err),
        .dtcm_ram_cs        (ram_cs),
        .dtcm_ram_we        (ram_we),
        .dtcm_ram_addr      (ram_addr),
        .dtcm_ram_wem       (ram_wem),
        .dtcm_ram_din       (ram_din),
        .dtcm_ram_dout      (ram_dout)
    );

    // Synchronous single-port SRAM, one-cycle read latency.
    always @(posedge clk) begin
        if (bd_we) begin
            ram[bd_addr] <= bd_data;
        end else if (ram_cs) begin
            if (ram_we) begin
                for (int b = 0; b < c_MW; b++)
                    if (ram_wem[b]) ram[ram_addr[5:0]][8*b +: 8] <= ram_din[8*b +: 8];
            end else begin
                ram_dout <= ram[ram_addr[5:0]];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle with the inputs already driven. Checks happen on the
    // falling edge; the reference model then absorbs the coming handshakes.
    task automatic step(output bit acc);
        bit   mis;
        int   w;
        rsp_t e;
        @(negedge clk);
        check("cmd_ready", cmd_ready, sb.size() < c_D);
        check("rsp_valid", rsp_valid, sb.size() > 0);
        if (rsp_valid && sb.size() > 0) begin
            check("rsp_rdata", rsp_rdata, sb[0].data);
            check("rsp_err", rsp_err, sb[0].err);
        end
        acc = cmd_valid && cmd_ready;
        mis = (cmd_addr[1:0] != 2'b00);
        check("ram_cs", ram_cs, acc && !mis);
        if (acc && !mis) begin
            check("ram_addr", ram_addr, cmd_addr[15:2]);
            check("ram_we", ram_we, !cmd_read);
            if (!cmd_read) begin
                check("ram_wem", ram_wem, cmd_wmask);
                check("ram_din", ram_din, cmd_wdata);
            end
        end
        if (rsp_valid && rsp_ready && sb.size() > 0) void'(sb.pop_front());
        if (acc) begin
            w = int'(cmd_addr[7:2]);
            e.err  = mis;
            e.data = '0;
            if (!mis && cmd_read) e.data = ref_mem[w];
            if (!mis && !cmd_read)
                for (int b = 0; b < c_MW; b++)
                    if (cmd_wmask[b]) ref_mem[w][8*b +: 8] = cmd_wdata[8*b +: 8];
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    // Hold a command until it is accepted, within a cycle budget.
    task automatic send(input bit rd, input logic [c_AW-1:0] a,
                        input logic [c_MW-1:0] m, input logic [c_DW-1:0] d);
        bit acc;
        bit done = 0;
        cmd_valid = 1'b1;
        cmd_read  = rd;
        cmd_addr  = a;
        cmd_wmask = m;
        cmd_wdata = d;
        for (int i = 0; i < 20 && !done; i++) begin
            step(acc);
            done = acc;
        end
        if (!done) check("send_timeout", 0, 1);
        cmd_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bit acc;
        cmd_valid = 1'b0;
        for (int i = 0; i < n; i++) step(acc);
    endtask

    initial begin
        bit              acc;
        int              idx;
        logic [c_AW-1:0] bp_addr [3];

        // preload both memories while reset is held
        for (int i = 0; i < 64; i++) begin
            bd_we   = 1'b1;
            bd_addr = 6'(i);
            case (i)
                0:       bd_data = 32'h1111_1111;
                1:       bd_data = 32'h2222_2222;
                2:       bd_data = 32'h0000_0000;
                default: bd_data = $urandom;
            endcase
            ref_mem[i] = bd_data;
            @(posedge clk);
            #1;
        end
        bd_we = 1'b0;

        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_ram_cs", ram_cs, 0);
        rst_n = 1'b1;

        // back-to-back reads
        rsp_ready = 1'b1;
        send(1, 16'h0000, 4'h0, 32'h0);
        send(1, 16'h0004, 4'h0, 32'h0);
        idle(3);

        // byte-masked write then read
        send(0, 16'h0008, 4'b0101, 32'hAABB_CCDD);
        send(1, 16'h0008, 4'h0, 32'h0);
        idle(3);
        check("masked_word", ref_mem[2], 32'h00BB_00DD);

        // misaligned read
        send(1, 16'h0006, 4'h0, 32'h0);
        idle(3);

        // backpressure: three reads against a stalled response port
        bp_addr[0] = 16'h0000;
        bp_addr[1] = 16'h0004;
        bp_addr[2] = 16'h0008;
        rsp_ready = 1'b0;
        idx = 0;
        for (int i = 0; i < 6; i++) begin
            cmd_valid = (idx < 3);
            cmd_read  = 1'b1;
            cmd_addr  = bp_addr[idx < 3 ? idx : 2];
            step(acc);
            if (acc) idx++;
        end
        check("bp_accepts", idx, c_D);
        rsp_ready = 1'b1;
        for (int i = 0; i < 20 && (idx < 3 || sb.size() > 0); i++) begin
            cmd_valid = (idx < 3);
            cmd_addr  = bp_addr[idx < 3 ? idx : 2];
            step(acc);
            if (acc) idx++;
        end
        check("bp_drained", sb.size(), 0);
        idle(2);

        // reset while responses are buffered
        rsp_ready = 1'b0;
        cmd_valid = 1'b1;
        cmd_read  = 1'b1;
        cmd_addr  = 16'h0004;
        for (int i = 0; i < 4; i++) step(acc);
        check("pre_rst_rsp_valid", rsp_valid, 1);
        cmd_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_cmd_ready", cmd_ready, 1);
        check("mid_rst_rsp_rdata", rsp_rdata, 0);
        check("mid_rst_rsp_err", rsp_err, 0);
        sb.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        idle(4);

        // continuous reads with rsp_ready high: accept pattern follows depth
        begin
            int n_acc = 0;
            cmd_valid = 1'b1;
            cmd_read  = 1'b1;
            for (int i = 0; i < 8; i++) begin
                cmd_addr = 16'(($urandom_range(0, 15)) * 4);
                step(acc);
                if (acc) n_acc++;
            end
            check("stream_accepts", n_acc, (c_D == 2) ? 8 : 4);
            idle(3);
        end

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            cmd_valid = ($urandom_range(0, 3) != 0);
            cmd_read  = $urandom_range(0, 1) == 1;
            cmd_addr  = 16'($urandom_range(0, 15) * 4);
            if ($urandom_range(0, 7) == 0) cmd_addr[1:0] = 2'($urandom_range(1, 3));
            cmd_wmask = 4'($urandom_range(0, 15));
            cmd_wdata = $urandom;
            rsp_ready = ($urandom_range(0, 3) != 0);
            step(acc);
        end
        rsp_ready = 1'b1;
        idle(6);
        check("final_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dtcm_ctrl_pipe.md
# dtcm_ctrl_pipe

Parametrised, pipelined DTCM controller between the LSU command/response interface and a synchronous single-port data SRAM with one-cycle read latency. It replaces the same-cycle, always-ready response model with a real valid/ready handshake on both channels. It adds in-order response buffering under backpressure and misaligned-access error responses. It sits inside the core's memory subsystem, with the LSU as its only master.

## Interface
Parameters:
- DTCM_AW, 16, byte address width of the command address
- DTCM_DW, 32, data width; must be a power of two and at least 8
- DTCM_MW, DTCM_DW/8, byte-mask width (derived)
- DTCM_RAM_AW, DTCM_AW-log2(DTCM_MW), word address width (derived)

Ports:
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- lsu2dtcm_cmd_valid  in  1  command valid
- lsu2dtcm_cmd_ready  out  1  command ready
- lsu2dtcm_cmd_read  in  1  1 = read, 0 = write
- lsu2dtcm_cmd_addr  in  DTCM_AW  byte address
- lsu2dtcm_cmd_wmask  in  DTCM_MW  write byte enables
- lsu2dtcm_cmd_wdata  in  DTCM_DW  write data
- lsu2dtcm_rsp_valid  out  1  response valid
- lsu2dtcm_rsp_ready  in  1  response ready
- lsu2dtcm_rsp_rdata  out  DTCM_DW  read data; 0 for writes and errors
- lsu2dtcm_rsp_err  out  1  misaligned access
- dtcm_ram_cs  out  1  RAM chip select
- dtcm_ram_we  out  1  RAM write enable
- dtcm_ram_addr  out  DTCM_RAM_AW  RAM word address
- dtcm_ram_wem  out  DTCM_MW  RAM byte write mask
- dtcm_ram_din  out  DTCM_DW  RAM write data
- dtcm_ram_dout  in  DTCM_DW  RAM read data, valid the cycle after cs

## Operation
- Accept: cmd_valid & cmd_ready in the same cycle.
- Aligned accept: the low log2(DTCM_MW) address bits are 0.
  - ram_cs = 1 and ram_we = ~cmd_read.
  - ram_addr = cmd_addr[DTCM_AW-1:log2(DTCM_MW)].
  - ram_wem = cmd_read ? 0 : cmd_wmask; ram_din = cmd_wdata.
  - All RAM outputs are combinational from the command.
- Misaligned accept: ram_cs = 0. The command still takes a response slot and returns err=1 with rdata=0.
- A write with wmask = 0 still asserts ram_cs and returns a normal response.
- Stage-1 state: pend, pend_read and pend_err registers mark the cycle in which ram_dout is live.
- Response data = pend_read & ~pend_err ? ram_dout : 0.
- Response FIFO of depth D (see Configuration). Responses are always returned in order.
  - If the FIFO is empty and pend = 1, the stage-1 response is presented directly (bypass).
  - If the FIFO is non-empty, the FIFO head is presented.
  - A stage-1 response not consumed in its cycle is pushed into the FIFO.
- cmd_ready = (pend + fifo_count) < D, computed from registers only. There is no combinational path from rsp_ready to cmd_ready.
- Simultaneous FIFO pop and push in one cycle: the count is unchanged and order is kept.
- Reset (asynchronous, any time): clears pend, the FIFO and its pointers; in-flight responses are discarded.
  - Output values during and after reset: cmd_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - RAM outputs: ram_cs = 0 unless cmd_valid = 1.

## Timing
- Latency: the response is valid in the cycle after accept when the FIFO is empty.
- FIFO occupancy adds one cycle of latency per queued entry.
- Throughput with D = 2 and rsp_ready held at 1: one command per cycle.
- With D = 1: one command every two cycles.
- Backpressure with D = 2:
  - At most one in-flight access plus two buffered responses. pend + count never exceeds 2 at accept time.
  - RAM data is never lost, because a push is always possible when pend = 1.
- rsp_valid stays asserted with stable rdata and err until rsp_ready.

## Configuration
- DTCM_CTRL_RSP_BUF_EN defined: D = 2, 2-entry response FIFO, full throughput.
- DTCM_CTRL_RSP_BUF_EN undefined: D = 1, 1-entry hold register, half throughput, minimum area.
- The interface and response ordering are identical in both builds.

## Test plan
- Back-to-back reads, rsp_ready = 1, macro on:
  - Stimulus: RAM preloaded with 0x11111111 at 0x0 and 0x22222222 at 0x4; reads issued on consecutive cycles.
  - Required response: one response per cycle, 0x11111111 then 0x22222222, each one cycle after its accept.
- Byte-masked write then read:
  - Stimulus: write 0xAABBCCDD with wmask 4'b0101 to word 0x8, which holds 0x00000000; then read 0x8.
  - Required response: the write returns rdata = 0, err = 0; the read returns 0x00BB00DD.
- Backpressure, macro on:
  - Stimulus: rsp_ready = 0 while three reads are issued.
  - Required response: cmd_ready drops after two accepts. After rsp_ready rises, responses come out in issue order with no loss.
- Misaligned access:
  - Stimulus: read at address 0x6.
  - Required response: ram_cs stays 0; the response has err = 1 and rdata = 0.
- Reset mid-operation:
  - Stimulus: pull rst_n low while two responses are buffered.
  - Required response: rsp_valid = 0 immediately and cmd_ready = 1. No stale response appears after reset is released.
- Macro off:
  - Stimulus: continuous reads with rsp_ready = 1.
  - Required response: cmd_ready toggles, giving accepts on every other cycle; data stays correct.
